// File: rtl/alu_pkg.sv
// Shared ALU op codes and operand-select encodings for the issue and execute stages.
package alu_pkg;

    localparam logic [3:0] ALU_ADD      = 4'b0000;
    localparam logic [3:0] ALU_SUB      = 4'b1000;
    localparam logic [3:0] ALU_SLL      = 4'b0001;
    localparam logic [3:0] ALU_SLT      = 4'b0010;
    localparam logic [3:0] ALU_SLTU     = 4'b0011;
    localparam logic [3:0] ALU_XOR      = 4'b0100;
    localparam logic [3:0] ALU_SRL      = 4'b0101;
    localparam logic [3:0] ALU_OR       = 4'b0110;
    localparam logic [3:0] ALU_AND      = 4'b0111;
    localparam logic [3:0] ALU_LUI_COPY = 4'b1001;
    localparam logic [3:0] ALU_SRA      = 4'b1101;

    localparam logic SRCA_RS1 = 1'b0;
    localparam logic SRCA_PC  = 1'b1;
    localparam logic SRCB_RS2 = 1'b0;
    localparam logic SRCB_IMM = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass: picks EX/MEM result, then MEM/WB result, then register-file data.
module fwd_mux
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      addr,
    input  logic [XLEN-1:0] id_data,
    input  logic            mem_en,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data
);

    logic mem_hit_s;
    logic wb_hit_s;

    // x0 is never bypassed; it always reads the register-file value (zero).
    always_comb begin
        mem_hit_s = mem_en && (mem_rd == addr) && (addr != REG_ZERO);
        wb_hit_s  = wb_en  && (wb_rd  == addr) && (addr != REG_ZERO);
    end

    // Younger producer (EX/MEM) wins over older (MEM/WB).
    always_comb begin
        if (mem_hit_s) begin
            data = mem_data;
        end else if (wb_hit_s) begin
            data = wb_data;
        end else begin
            data = id_data;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Single-entry ID->EX pipeline register with operand forwarding and source selection.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic [3:0]      id_alu_sel,
    input  logic            id_srca_sel,
    input  logic            id_srcb_sel,
    input  logic            id_reg_write,
    input  logic            mem_fwd_en,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_fwd_en,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] srca,
    output logic [XLEN-1:0] srcb,
    output logic [3:0]      alu_sel,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_reg_write,
    output logic [XLEN-1:0] ex_store_data
);

    logic [XLEN-1:0] rs1_fwd_s;
    logic [XLEN-1:0] rs2_fwd_s;
    logic [XLEN-1:0] srca_next_s;
    logic [XLEN-1:0] srcb_next_s;
    logic            id_ready_s;
    logic            capture_s;

    logic            ex_valid_r;
    logic            ex_reg_write_r;
    logic [XLEN-1:0] srca_r;
    logic [XLEN-1:0] srcb_r;
    logic [XLEN-1:0] store_data_r;
    logic [3:0]      alu_sel_r;
    logic [4:0]      rd_addr_r;

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .addr     (id_rs1_addr),
        .id_data  (id_rs1_data),
        .mem_en   (mem_fwd_en),
        .mem_rd   (mem_fwd_rd),
        .mem_data (mem_fwd_data),
        .wb_en    (wb_fwd_en),
        .wb_rd    (wb_fwd_rd),
        .wb_data  (wb_fwd_data),
        .data     (rs1_fwd_s)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .addr     (id_rs2_addr),
        .id_data  (id_rs2_data),
        .mem_en   (mem_fwd_en),
        .mem_rd   (mem_fwd_rd),
        .mem_data (mem_fwd_data),
        .wb_en    (wb_fwd_en),
        .wb_rd    (wb_fwd_rd),
        .wb_data  (wb_fwd_data),
        .data     (rs2_fwd_s)
    );

    // Handshake: the slot is free when empty or being drained this cycle.
    always_comb begin
        id_ready_s = !ex_valid_r || ex_ready;
        capture_s  = id_valid && id_ready_s && !flush;
    end

    // Operand source selection applied to the already-forwarded values.
    always_comb begin
        if (id_srca_sel == SRCA_PC) begin
            srca_next_s = id_pc;
        end else begin
            srca_next_s = rs1_fwd_s;
        end
        if (id_srcb_sel == SRCB_IMM) begin
            srcb_next_s = id_imm;
        end else begin
            srcb_next_s = rs2_fwd_s;
        end
    end

    // Control flops: flush beats capture, capture beats drain, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r     <= 1'b0;
            ex_reg_write_r <= 1'b0;
        end else if (flush) begin
            ex_valid_r     <= 1'b0;
            ex_reg_write_r <= 1'b0;
        end else if (capture_s) begin
            ex_valid_r     <= 1'b1;
            ex_reg_write_r <= id_reg_write;
        end else if (ex_ready) begin
            ex_valid_r     <= 1'b0;
            ex_reg_write_r <= ex_reg_write_r;
        end else begin
            ex_valid_r     <= ex_valid_r;
            ex_reg_write_r <= ex_reg_write_r;
        end
    end

    // Payload flops load only on capture, so operands are frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srca_r       <= {XLEN{1'b0}};
            srcb_r       <= {XLEN{1'b0}};
            store_data_r <= {XLEN{1'b0}};
            alu_sel_r    <= ALU_ADD;
            rd_addr_r    <= 5'd0;
        end else if (capture_s) begin
            srca_r       <= srca_next_s;
            srcb_r       <= srcb_next_s;
            store_data_r <= rs2_fwd_s;
            alu_sel_r    <= id_alu_sel;
            rd_addr_r    <= id_rd_addr;
        end else begin
            srca_r       <= srca_r;
            srcb_r       <= srcb_r;
            store_data_r <= store_data_r;
            alu_sel_r    <= alu_sel_r;
            rd_addr_r    <= rd_addr_r;
        end
    end

    assign id_ready      = id_ready_s;
    assign ex_valid      = ex_valid_r;
    assign ex_reg_write  = ex_reg_write_r;
    assign srca          = srca_r;
    assign srcb          = srcb_r;
    assign ex_store_data = store_data_r;
    assign alu_sel       = alu_sel_r;
    assign ex_rd_addr    = rd_addr_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: vector table for capture/forwarding plus stall, flush and reset sequences.
module tb_alu_issue_stage;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1_addr;
    logic [4:0]      id_rs2_addr;
    logic [4:0]      id_rd_addr;
    logic [3:0]      id_alu_sel;
    logic            id_srca_sel;
    logic            id_srcb_sel;
    logic            id_reg_write;
    logic            mem_fwd_en;
    logic [4:0]      mem_fwd_rd;
    logic [XLEN-1:0] mem_fwd_data;
    logic            wb_fwd_en;
    logic [4:0]      wb_fwd_rd;
    logic [XLEN-1:0] wb_fwd_data;
    logic            flush;
    logic            ex_ready;
    logic            ex_valid;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic [3:0]      alu_sel;
    logic [4:0]      ex_rd_addr;
    logic            ex_reg_write;
    logic [XLEN-1:0] ex_store_data;

    int n_cmp;
    int n_bad;

    alu_issue_stage #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_pc         (id_pc),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_rd_addr    (id_rd_addr),
        .id_alu_sel    (id_alu_sel),
        .id_srca_sel   (id_srca_sel),
        .id_srcb_sel   (id_srcb_sel),
        .id_reg_write  (id_reg_write),
        .mem_fwd_en    (mem_fwd_en),
        .mem_fwd_rd    (mem_fwd_rd),
        .mem_fwd_data  (mem_fwd_data),
        .wb_fwd_en     (wb_fwd_en),
        .wb_fwd_rd     (wb_fwd_rd),
        .wb_fwd_data   (wb_fwd_data),
        .flush         (flush),
        .ex_ready      (ex_ready),
        .ex_valid      (ex_valid),
        .srca          (srca),
        .srcb          (srcb),
        .alu_sel       (alu_sel),
        .ex_rd_addr    (ex_rd_addr),
        .ex_reg_write  (ex_reg_write),
        .ex_store_data (ex_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1_addr;
        logic [31:0] rs1_data;
        logic [4:0]  rs2_addr;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        srca_sel;
        logic        srcb_sel;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        rw;
        logic        m_en;
        logic [4:0]  m_rd;
        logic [31:0] m_data;
        logic        w_en;
        logic [4:0]  w_rd;
        logic [31:0] w_data;
        logic [31:0] exp_srca;
        logic [31:0] exp_srcb;
        logic [31:0] exp_store;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        id_rs1_addr  = v.rs1_addr;
        id_rs1_data  = v.rs1_data;
        id_rs2_addr  = v.rs2_addr;
        id_rs2_data  = v.rs2_data;
        id_imm       = v.imm;
        id_pc        = v.pc;
        id_srca_sel  = v.srca_sel;
        id_srcb_sel  = v.srcb_sel;
        id_alu_sel   = v.alu;
        id_rd_addr   = v.rd;
        id_reg_write = v.rw;
        mem_fwd_en   = v.m_en;
        mem_fwd_rd   = v.m_rd;
        mem_fwd_data = v.m_data;
        wb_fwd_en    = v.w_en;
        wb_fwd_rd    = v.w_rd;
        wb_fwd_data  = v.w_data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //        rs1   rs1_data     rs2   rs2_data     imm          pc           sa    sb    alu      rd     rw    men   mrd   mdata        wen   wrd   wdata        srca         srcb         store
        vecs[0] = '{5'd1, 32'd5,      5'd2, 32'd9,      32'd7,      32'h0,      1'b0, 1'b1, 4'b0000, 5'd10, 1'b1, 1'b0, 5'd0, 32'h0,      1'b0, 5'd0, 32'h0,      32'd5,      32'd7,      32'd9};
        vecs[1] = '{5'd3, 32'h11,     5'd0, 32'h0,      32'h0,      32'h0,      1'b0, 1'b0, 4'b1000, 5'd11, 1'b1, 1'b1, 5'd3, 32'hAA,     1'b1, 5'd3, 32'hBB,     32'hAA,     32'h0,      32'h0};
        vecs[2] = '{5'd3, 32'h11,     5'd0, 32'h0,      32'h0,      32'h0,      1'b0, 1'b0, 4'b0010, 5'd11, 1'b1, 1'b0, 5'd3, 32'hAA,     1'b1, 5'd3, 32'hBB,     32'hBB,     32'h0,      32'h0};
        vecs[3] = '{5'd1, 32'd3,      5'd0, 32'h0,      32'h0,      32'h0,      1'b0, 1'b0, 4'b0011, 5'd0,  1'b0, 1'b1, 5'd0, 32'h55,     1'b1, 5'd0, 32'h66,     32'd3,      32'h0,      32'h0};
        vecs[4] = '{5'd7, 32'h70,     5'd4, 32'h40,     32'h0,      32'h1000,   1'b1, 1'b0, 4'b0100, 5'd12, 1'b1, 1'b1, 5'd5, 32'h5,      1'b1, 5'd4, 32'h44,     32'h1000,   32'h44,     32'h44};
        vecs[5] = '{5'd8, 32'h80,     5'd6, 32'h60,     32'h20,     32'h0,      1'b0, 1'b1, 4'b1111, 5'd31, 1'b1, 1'b1, 5'd6, 32'h66,     1'b1, 5'd8, 32'h88,     32'h88,     32'h20,     32'h66};
        vecs[6] = '{5'd9, 32'h90,     5'd9, 32'h90,     32'h0,      32'h0,      1'b0, 1'b0, 4'b1101, 5'd9,  1'b0, 1'b1, 5'd9, 32'h99,     1'b1, 5'd9, 32'h77,     32'h99,     32'h99,     32'h99};

        rst_n    = 1'b0;
        id_valid = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        drive_vec(vecs[0]);
        #12;
        check("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        check("reset id_ready", {31'd0, id_ready}, 32'd1);
        check("reset alu_sel", {28'd0, alu_sel}, 32'd0);
        check("reset srca", srca, 32'd0);
        check("reset reg_write", {31'd0, ex_reg_write}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: one instruction per cycle with the consumer always ready.
        id_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive_vec(vecs[i]);
            tick();
            check($sformatf("v%0d ex_valid", i), {31'd0, ex_valid}, 32'd1);
            check($sformatf("v%0d srca", i), srca, vecs[i].exp_srca);
            check($sformatf("v%0d srcb", i), srcb, vecs[i].exp_srcb);
            check($sformatf("v%0d store", i), ex_store_data, vecs[i].exp_store);
            check($sformatf("v%0d alu_sel", i), {28'd0, alu_sel}, {28'd0, vecs[i].alu});
            check($sformatf("v%0d rd", i), {27'd0, ex_rd_addr}, {27'd0, vecs[i].rd});
            check($sformatf("v%0d reg_write", i), {31'd0, ex_reg_write}, {31'd0, vecs[i].rw});
        end

        // Drain with no new instruction.
        id_valid = 1'b0;
        tick();
        check("drain ex_valid", {31'd0, ex_valid}, 32'd0);

        // Stall: hold A for three cycles while B waits, forwarding changes meanwhile.
        id_valid = 1'b1;
        drive_vec(vecs[0]);
        tick();
        check("stall A srca", srca, 32'd5);
        ex_ready = 1'b0;
        id_rs1_data = 32'hB2;
        id_imm = 32'h3;
        id_alu_sel = 4'b0110;
        mem_fwd_en = 1'b1;
        mem_fwd_rd = 5'd1;
        mem_fwd_data = 32'hDEAD;
        #1;
        check("stall id_ready", {31'd0, id_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall%0d ex_valid", c), {31'd0, ex_valid}, 32'd1);
            check($sformatf("stall%0d srca", c), srca, 32'd5);
            check($sformatf("stall%0d srcb", c), srcb, 32'd7);
            check($sformatf("stall%0d alu_sel", c), {28'd0, alu_sel}, 32'd0);
            check($sformatf("stall%0d id_ready", c), {31'd0, id_ready}, 32'd0);
        end
        ex_ready = 1'b1;
        mem_fwd_en = 1'b0;
        #1;
        check("release id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        check("release B srca", srca, 32'hB2);
        check("release B srcb", srcb, 32'h3);
        check("release B alu_sel", {28'd0, alu_sel}, 32'd6);
        check("release B ex_valid", {31'd0, ex_valid}, 32'd1);

        // Flush with an incoming instruction: nothing captured, payload kept.
        drive_vec(vecs[4]);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush ex_valid", {31'd0, ex_valid}, 32'd0);
        check("flush reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("flush srca kept", srca, 32'hB2);

        // Flush overrides a held instruction.
        drive_vec(vecs[0]);
        tick();
        ex_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush stall ex_valid", {31'd0, ex_valid}, 32'd0);
        check("flush stall reg_write", {31'd0, ex_reg_write}, 32'd0);

        // Reset mid-stall takes effect without a clock edge.
        ex_ready = 1'b1;
        drive_vec(vecs[2]);
        tick();
        ex_ready = 1'b0;
        tick();
        check("pre-reset ex_valid", {31'd0, ex_valid}, 32'd1);
        check("pre-reset alu_sel", {28'd0, alu_sel}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("async ex_valid", {31'd0, ex_valid}, 32'd0);
        check("async alu_sel", {28'd0, alu_sel}, 32'd0);
        check("async srca", srca, 32'd0);
        check("async id_ready", {31'd0, id_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ex_ready = 1'b1;
        drive_vec(vecs[5]);
        tick();
        check("post-reset ex_valid", {31'd0, ex_valid}, 32'd1);
        check("post-reset srca", srca, 32'h88);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
